// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the data-memory responder: default data width,
// load/store funct3 encodings, responder FSM states and access-decode helpers.
package riscv_pkg;

  localparam int DW = 32;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  function automatic logic f3_supported(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end else begin
      ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
    end
    return ok;
  endfunction

  // Low address bits that survive alignment: halfwords drop bit 0, words drop both.
  function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [1:0] off);
    logic [1:0] r;
    case (f3[1:0])
      2'd0:    r = off;
      2'd1:    r = {off[1], 1'b0};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic m;
    case (f3[1:0])
      2'd1:    m = off[0];
      2'd2:    m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port RAM, 2**AW words of DW bits, with per-byte write enables.
// Read data is registered and holds its value while the port is idle.
module dmem_array #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [DW/8-1:0]   be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DW-1:0]     wdata_i,
  output logic [DW-1:0]     rdata_o
);

  logic [DW-1:0] mem_r [0:(1<<AW)-1];

  // Read-before-write access with byte-lane masking on stores.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_o <= mem_r[addr_i];
      if (we_i) begin
        for (int b = 0; b < DW/8; b++) begin
          if (be_i[b]) begin
            mem_r[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: fixed-latency load/store slave for an RV32I core.
// Define DMEM_MISALIGN_CHK_EN to fault misaligned halfword/word accesses instead of aligning them.
module data_mem_resp #(
  parameter int DW      = riscv_pkg::DW,
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [DW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  input  logic [2:0]    req_funct3_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          rsp_err_o
);

  import riscv_pkg::*;

  localparam int         BW      = DW / 8;
  localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);
  localparam bit         LAT_ONE = (LATENCY == 1);

  dmem_state_e   state_r;
  logic [3:0]    cnt_r;
  logic          ready_r;
  logic          rsp_valid_r;
  logic          rsp_err_r;
  logic          we_r;
  logic [AW+1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic [2:0]    funct3_r;

  logic          acc_fire_s;
  logic          acc_we_s;
  logic          acc_err_s;
  logic [AW+1:0] acc_addr_s;
  logic [DW-1:0] acc_wdata_s;
  logic [2:0]    acc_funct3_s;
  logic [1:0]    acc_off_s;
  logic          ram_we_s;
  logic [BW-1:0] ram_be_s;
  logic [DW-1:0] ram_wdata_s;
  logic [DW-1:0] ram_rdata_s;
  logic          unused_s;

  function automatic logic [DW-1:0] load_fmt(input logic [DW-1:0] word,
                                             input logic [2:0] f3, input logic [1:0] off);
    logic [DW-1:0] sh;
    logic [DW-1:0] r;
    sh = word >> {off, 3'b000};
    case (f3)
      F3_LB:   r = {{(DW-8){sh[7]}}, sh[7:0]};
      F3_LH:   r = {{(DW-16){sh[15]}}, sh[15:0]};
      F3_LBU:  r = {{(DW-8){1'b0}}, sh[7:0]};
      F3_LHU:  r = {{(DW-16){1'b0}}, sh[15:0]};
      F3_LW:   r = word;
      default: r = {DW{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic [BW-1:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [BW-1:0] r;
    case (f3[1:0])
      2'd0:    r = {{(BW-1){1'b0}}, 1'b1} << off;
      2'd1:    r = {{(BW-2){1'b0}}, 2'b11} << off;
      2'd2:    r = {BW{1'b1}};
      default: r = {BW{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] store_data(input logic [2:0] f3, input logic [DW-1:0] wd);
    logic [DW-1:0] r;
    case (f3[1:0])
      2'd0:    r = {BW{wd[7:0]}};
      2'd1:    r = {(BW/2){wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Operands come straight from the request when the access fires on acceptance (LATENCY=1).
  always_comb begin
    if (state_r == IDLE) begin
      acc_we_s     = req_we_i;
      acc_addr_s   = req_addr_i[AW+1:0];
      acc_wdata_s  = req_wdata_i;
      acc_funct3_s = req_funct3_i;
    end else begin
      acc_we_s     = we_r;
      acc_addr_s   = addr_r;
      acc_wdata_s  = wdata_r;
      acc_funct3_s = funct3_r;
    end
    acc_off_s = eff_off(acc_funct3_s, acc_addr_s[1:0]);
`ifdef DMEM_MISALIGN_CHK_EN
    acc_err_s = !f3_supported(acc_we_s, acc_funct3_s) ||
                misaligned(acc_funct3_s, acc_addr_s[1:0]);
`else
    acc_err_s = !f3_supported(acc_we_s, acc_funct3_s);
`endif
    if (rst_i) begin
      acc_fire_s = 1'b0;
    end else if (state_r == IDLE) begin
      acc_fire_s = req_valid_i && LAT_ONE;
    end else if (state_r == WAIT) begin
      acc_fire_s = (cnt_r == LAT_M1);
    end else begin
      acc_fire_s = 1'b0;
    end
    ram_we_s    = acc_we_s && !acc_err_s;
    ram_be_s    = store_be(acc_funct3_s, acc_off_s);
    ram_wdata_s = store_data(acc_funct3_s, acc_wdata_s);
  end

  dmem_array #(.DW(DW), .AW(AW)) u_array (
    .clk_i   (clk_i),
    .en_i    (acc_fire_s),
    .we_i    (ram_we_s),
    .be_i    (ram_be_s),
    .addr_i  (acc_addr_s[AW+1:2]),
    .wdata_i (ram_wdata_s),
    .rdata_o (ram_rdata_s)
  );

  // Request/response FSM; the RAM access coincides with every edge that enters RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= {(AW+2){1'b0}};
      wdata_r     <= {DW{1'b0}};
      funct3_r    <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid_i) begin
            we_r     <= req_we_i;
            addr_r   <= req_addr_i[AW+1:0];
            wdata_r  <= req_wdata_i;
            funct3_r <= req_funct3_i;
            ready_r  <= 1'b0;
            if (LAT_ONE) begin
              state_r     <= RESP;
              cnt_r       <= 4'd0;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= acc_err_s;
            end else begin
              state_r <= WAIT;
              cnt_r   <= 4'd1;
            end
          end
        end
        WAIT: begin
          if (cnt_r == LAT_M1) begin
            state_r     <= RESP;
            cnt_r       <= 4'd0;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= acc_err_s;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_r     <= IDLE;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= 4'd0;
          ready_r     <= 1'b1;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  // Reset forces idle handshake values in the very cycle it is asserted.
  assign req_ready_o = ready_r || rst_i;
  assign rsp_valid_o = rsp_valid_r && !rst_i;
  assign rsp_err_o   = rsp_err_r && !rst_i;
  assign rsp_rdata_o = (rsp_valid_o && !rsp_err_r && !we_r) ?
                       load_fmt(ram_rdata_s, funct3_r, eff_off(funct3_r, addr_r[1:0])) :
                       {DW{1'b0}};

  assign unused_s = ^req_addr_i[DW-1:AW+2];

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DW, default 32: data and address width in bits.
REQ-002 Parameter AW, default 10: word-index width; storage is 2**AW words of DW bits (4 KiB at defaults).
REQ-003 Parameter LATENCY, default 2: cycles from request acceptance to rsp_valid_o; legal range 1..15.
REQ-004 clk_i  in  1  single clock; every register updates on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 req_valid_i  in  1  CPU presents a load/store request.
REQ-007 req_ready_o  out  1  responder accepts a request this cycle.
REQ-008 req_we_i  in  1  1 = store, 0 = load.
REQ-009 req_addr_i  in  DW  byte address.
REQ-010 req_wdata_i  in  DW  store data, right-aligned.
REQ-011 req_funct3_i  in  3  RV32I load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-012 rsp_valid_o  out  1  response available.
REQ-013 rsp_ready_i  in  1  CPU consumes the response.
REQ-014 rsp_rdata_o  out  DW  load result, extended per funct3; 0 for stores and errors.
REQ-015 rsp_err_o  out  1  access faulted; qualified by rsp_valid_o.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-017 req_ready_o SHALL be 1 only in IDLE.
REQ-018 On a rising edge with req_valid_i=1 in IDLE, the block SHALL latch we, addr, wdata and funct3 and enter WAIT, or enter RESP directly when LATENCY=1.
REQ-019 In WAIT a 4-bit counter SHALL hold the FSM so that rsp_valid_o rises exactly LATENCY cycles after the acceptance cycle.
REQ-020 The memory access (store commit or load read) SHALL happen once, on the edge entering RESP.
REQ-021 In RESP, rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL stay stable until rsp_ready_i=1; that edge SHALL return the FSM to IDLE.
REQ-022 A new request SHALL NOT be accepted in the same cycle as a response handshake; the minimum request spacing is LATENCY+1 cycles.
REQ-023 Word index SHALL be addr[AW+1:2]; address bits above AW+1 SHALL be ignored, so accesses wrap modulo 2**(AW+2) bytes.
REQ-024 SB/SH/SW SHALL write byte lanes addr[1:0], addr[1]*2 (two bytes) or all four respectively; other lanes SHALL be unchanged.
REQ-025 LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend and LW SHALL return the word unchanged.
REQ-026 An unsupported funct3 (load 3/6/7, store 3..7) SHALL set rsp_err_o=1, perform no write and return rdata 0.
REQ-027 req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-028 rst_i SHALL put the FSM in IDLE with the counter at 0.
REQ-029 While rst_i=1 and on the first cycle after it: req_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0.
REQ-030 Reset asserted in WAIT SHALL abort the pending access with no write; reset SHALL NOT clear storage contents.

Configuration
REQ-031 With macro DMEM_MISALIGN_CHK_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL give rsp_err_o=1, no write and rdata 0.
REQ-032 Without DMEM_MISALIGN_CHK_EN, the offending low address bits SHALL be forced to zero and the access SHALL complete with rsp_err_o=0.

Structure
REQ-033 Shared package riscv_pkg SHALL hold the DW constant, the funct3 load/store encodings and the FSM state enum.
REQ-034 Storage SHALL be a sub-module dmem_array: a synchronous, byte-enable, single-port RAM of 2**AW x DW.

Verification
REQ-035 After reset: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata_o=0xDEADBEEF, rsp_valid_o exactly 2 cycles after acceptance, err=0.
REQ-036 SB 0x80 @0x11 over 0xDEADBEEF -> LB @0x11 returns 0xFFFFFF80, LBU returns 0x00000080, LW returns 0xDEAD80EF.
REQ-037 Hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o/data held, req_ready_o=0; a request driven meanwhile is ignored.
REQ-038 LW @0x12: with DMEM_MISALIGN_CHK_EN -> err=1, rdata 0; without it -> returns the word @0x10, err=0.
REQ-039 Assert rst_i during WAIT of SW 0x1 @0x20 -> following LW @0x20 returns the prior contents, not 0x1.
REQ-040 funct3=3 load and SW @0x1010 (AW=10) -> first gives err=1; second aliases @0x10, confirmed by LW @0x10.
